// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, constants and buffer entry type for the fetch stage
package if_stage_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DROP_W = 8;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] ADDR_MASK        = 32'hFFFF_FFFC;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for the instruction buffer and PC queue
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting guarantees space; a dropped push means that accounting broke.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !do_pop && !flush));

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC ownership, credit-limited fetch, redirect flush and stale drop
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  pc_count;
    logic [DROP_W-1:0] drop_cnt;
    logic [CNT_W:0]    credit_used;
    logic [ADDR_W-1:0] pc_head;
    logic              req_fire;
    logic              resp_stale;
    logic              resp_keep;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign resp_stale = (drop_cnt != '0);
    assign resp_keep  = imem_resp_valid && !resp_stale && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;

    // A same-cycle pop frees its slot so a 1-cycle memory can stream at full rate.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
    assign imem_req_valid = !rst && !redirect && (count != CNT_W'(DEPTH))
                            && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc & ADDR_MASK;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push_entry = '{inst: imem_resp_data, pc: pc_head};
    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // Every in-flight request becomes stale; a response landing now is discarded too.
            fetch_pc    <= redirect_pc & ADDR_MASK;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= imem_req_addr + PC_STEP;
            end
            case ({req_fire, resp_keep})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (imem_resp_valid && resp_stale) begin
                drop_cnt <= drop_cnt - DROP_W'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(INST_W + ADDR_W), .DEPTH(DEPTH)) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (resp_keep),
        .flush (redirect),
        .wdata (imem_req_addr),
        .rdata (pc_head),
        .count (pc_count)
    );

    pc_q_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
        pc_count == outstanding);

    no_unexpected_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && drop_cnt == '0 && outstanding == '0));

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a latency-configurable memory model
module tb_if_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          mem_lat = 1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    int          first_req_cyc = -1;
    int          first_inst_cyc = -1;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] last_req_addr = '0;
    logic [31:0] last_pop_pc = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock cycle: memory drives at negedge, DUT outputs sampled just after, inputs change after posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(mem_addr[0]);
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        if (redirect) begin
            check("no_req_on_redirect", imem_req_valid, 1'b0);
            sb.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                sb.push_back('{mem_data(exp_pc), exp_pc});
                mem_addr.push_back(imem_req_addr);
                mem_due.push_back(cyc + mem_lat);
                last_req_addr = imem_req_addr;
                req_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                exp_pc = exp_pc + 32'd4;
            end
            if (inst_valid && first_inst_cyc < 0) first_inst_cyc = cyc;
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    check("stray_inst", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("inst", inst, e.data);
                    check("inst_pc", inst_pc, e.pc);
                end
                last_pop_pc = inst_pc;
                pop_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] want);
        int start;
        start = req_cnt;
        for (int i = 0; i < 20 && req_cnt == start; i++) step();
        if (req_cnt == start) check({tag, "_timeout"}, 1'b0, 1'b1);
        else check(tag, last_req_addr, want);
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] want);
        int start;
        start = pop_cnt;
        for (int i = 0; i < 20 && pop_cnt == start; i++) step();
        if (pop_cnt == start) check({tag, "_timeout"}, 1'b0, 1'b1);
        else check(tag, last_pop_pc, want);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        int          rc0;
        int          n;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        #1;
        check("req_valid_after_rst", imem_req_valid, 1'b1);

        // Streaming with 1-cycle memory
        repeat (6) step();
        check("first_req_cyc", first_req_cyc, 0);
        check("first_inst_cyc", first_inst_cyc, 2);
        check("stream_reqs", req_cnt, 6);
        check("stream_pops", pop_cnt, 4);

        // Decode stall
        inst_ready = 1'b0;
        rc0 = req_cnt;
        repeat (3) step();
        h_inst = inst;
        h_pc   = inst_pc;
        repeat (7) step();
        check("stall_req_bound", (req_cnt - rc0) <= DEPTH, 1'b1);
        check("stall_req_valid", imem_req_valid, 1'b0);
        check("stall_inst_valid", inst_valid, 1'b1);
        check("stall_inst_stable", inst, h_inst);
        check("stall_pc_stable", inst_pc, h_pc);
        inst_ready = 1'b1;
        repeat (6) step();

        // Redirect with two requests in flight
        mem_lat = 3;
        n = 0;
        while (mem_addr.size() != 2 && n < 20) begin
            step();
            n++;
        end
        check("two_in_flight", mem_addr.size(), 2);
        do_redirect(32'h0000_0100);
        wait_req("redir_req_addr", 32'h0000_0100);
        wait_pop("redir_first_pc", 32'h0000_0100);
        mem_lat = 1;
        repeat (6) step();

        // Redirect coinciding with a response while decode is ready
        check("resp_pending_at_redirect", mem_addr.size() > 0, 1'b1);
        do_redirect(32'h0000_0040);
        check("no_stale_n1", inst_valid, 1'b0);
        step();
        check("no_stale_n2", inst_valid, 1'b0);
        wait_pop("redir2_first_pc", 32'h0000_0040);
        repeat (3) step();

        // Misaligned target and address wrap
        do_redirect(32'h0000_0203);
        wait_req("align_addr", 32'h0000_0200);
        repeat (3) step();
        do_redirect(32'hFFFF_FFFC);
        wait_req("wrap_lo", 32'hFFFF_FFFC);
        wait_req("wrap_hi", 32'h0000_0000);
        repeat (4) step();

        // Reset mid-stream with a full buffer
        inst_ready = 1'b0;
        n = 0;
        while (!(inst_valid && !imem_req_valid && mem_addr.size() == 0) && n < 20) begin
            step();
            n++;
        end
        check("full_before_rst", inst_valid && !imem_req_valid, 1'b1);
        #2;
        rst = 1'b1;
        imem_resp_valid = 1'b0;
        #1;
        check("midrst_req_valid", imem_req_valid, 1'b0);
        check("midrst_inst_valid", inst_valid, 1'b0);
        check("midrst_inst", inst, 32'h0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        check("midrst_req_addr", imem_req_addr, RST_PC);
        sb.delete();
        mem_addr.delete();
        mem_due.delete();
        exp_pc = RST_PC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inst_ready = 1'b1;
        wait_req("restart_addr", RST_PC);
        wait_pop("restart_pc", RST_PC);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
